// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types, constants and byte-array helpers for mem_arbiter.
//            The memory side uses a 4x8 byte array in which byte [0] holds
//            bits 31:24 of the word (big-endian order).
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam int NUM_REQ    = 2;
  localparam int REQ_CORE   = 0;
  localparam int REQ_LOADER = 1;

  // Element [0] is the leftmost, most significant byte of the packed array.
  typedef logic [0:3][7:0] mem_bytes_t;

  function automatic logic [31:0] pack_bytes(input mem_bytes_t b);
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic mem_bytes_t unpack_bytes(input logic [31:0] w);
    mem_bytes_t b;
    b[0] = w[31:24];
    b[1] = w[23:16];
    b[2] = w[15:8];
    b[3] = w[7:0];
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Bundles the requester handshake (req/we/addr/wdata in,
//            gnt/rvalid/rdata/busy out) and the memory port
//            (mem_addr/mem_data_in/mem_write_en out, mem_data_out in).
//   master : the environment - both requesters plus the memory itself
//   slave  : the arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) ();

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] we;
  logic [ADDR_W-1:0]  addr_0;
  logic [ADDR_W-1:0]  addr_1;
  logic [31:0]        wdata_0;
  logic [31:0]        wdata_1;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] rvalid;
  logic [31:0]        rdata;
  logic               busy;

  logic [ADDR_W-1:0]  mem_addr;
  mem_bytes_t         mem_data_in;
  logic               mem_write_en;
  mem_bytes_t         mem_data_out;

  modport master (
    output req, we, addr_0, addr_1, wdata_0, wdata_1, mem_data_out,
    input  gnt, rvalid, rdata, busy, mem_addr, mem_data_in, mem_write_en
  );

  modport slave (
    input  req, we, addr_0, addr_1, wdata_0, wdata_1, mem_data_out,
    output gnt, rvalid, rdata, busy, mem_addr, mem_data_in, mem_write_en
  );

endinterface
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick2
// Purpose  : Two-way round-robin pick, purely combinational.
//   ereq        in  2  effective requests
//   last_winner in  1  requester that won the previous arbitration
//   valid       out 1  at least one request present
//   winner      out 1  index of the winning requester
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick2 (
  input  logic [1:0] ereq,
  input  logic       last_winner,
  output logic       valid,
  output logic       winner
);

  assign valid = |ereq;

  // With a single request, winner is simply that bit's index (ereq[1]);
  // on contention the requester that did not win last time goes first.
  assign winner = (&ereq) ? ~last_winner : ereq[1];

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one data-memory port between the core (requester 0)
//            and the loader/debug port (requester 1). One access in flight.
//   clk    in  1   clock
//   rst_b  in  1   asynchronous active-low reset
//   halted in  1   core halted, masks requester 0
//   bus    slave   requester handshake + memory port (mem_arbiter_if)
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          halted,
  mem_arbiter_if.slave  bus
);

  localparam int                CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  arb_state_t          r_state;
  arb_state_t          w_state_next;

  logic [NUM_REQ-1:0]  w_ereq;
  logic                w_pick_valid;
  logic                w_pick_winner;
  logic                w_grant;

  logic                r_last_winner;
  logic                r_winner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [CNT_W-1:0]    r_cnt;
  logic [31:0]         r_rdata;

  assign w_ereq = {bus.req[REQ_LOADER], bus.req[REQ_CORE] & ~halted};

  rr_pick2 u_pick (
    .ereq        (w_ereq),
    .last_winner (r_last_winner),
    .valid       (w_pick_valid),
    .winner      (w_pick_winner)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_grant          = 1'b0;
    bus.gnt          = '0;
    bus.rvalid       = '0;
    bus.mem_write_en = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_grant                = 1'b1;
          bus.gnt[w_pick_winner] = 1'b1;
          w_state_next           = ACCESS;
        end
      end
      ACCESS: begin
        // The counter still holds its load value only in the first ACCESS
        // cycle, so this yields exactly one strobe per write.
        bus.mem_write_en = r_we && (r_cnt == CNT_INIT);
        if (r_cnt == '0) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        bus.rvalid[r_winner] = 1'b1;
        w_state_next         = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_last_winner <= 1'b1;
      r_winner      <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_cnt         <= '0;
      r_rdata       <= '0;
    end else begin
      if (w_grant) begin
        r_winner      <= w_pick_winner;
        r_last_winner <= w_pick_winner;
        r_we          <= bus.we[w_pick_winner];
        r_addr        <= w_pick_winner ? bus.addr_1 : bus.addr_0;
        r_wdata       <= w_pick_winner ? bus.wdata_1 : bus.wdata_0;
        r_cnt         <= CNT_INIT;
      end else if ((r_state == ACCESS) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      // Writes leave the previous read data in place.
      if ((r_state == ACCESS) && (r_cnt == '0) && !r_we) begin
        r_rdata <= pack_bytes(bus.mem_data_out);
      end
    end
  end

  // Address and write data are registered at grant time, so outside ACCESS
  // the memory port naturally keeps showing the last access.
  assign bus.mem_addr    = r_addr;
  assign bus.mem_data_in = unpack_bytes(r_wdata);
  assign bus.rdata       = r_rdata;
  assign bus.busy        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. dut_a runs with a memory
//            latency of 3, dut_b with a latency of 1. Expected grants and
//            responses are queued by the stimulus and checked by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT_A = 3;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  logic rst_b;
  logic halted_a;
  logic halted_b;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32)) bus_a ();
  mem_arbiter_if #(.ADDR_W(32)) bus_b ();

  mem_arbiter #(.MEM_LATENCY(LAT_A), .ADDR_W(32)) dut_a (
    .clk(clk), .rst_b(rst_b), .halted(halted_a), .bus(bus_a.slave)
  );
  mem_arbiter #(.MEM_LATENCY(LAT_B), .ADDR_W(32)) dut_b (
    .clk(clk), .rst_b(rst_b), .halted(halted_b), .bus(bus_b.slave)
  );

  // ---------------- memory model ----------------
  function automatic mem_bytes_t tb_bytes(input logic [31:0] w);
    mem_bytes_t b;
    b[0] = w[31:24]; b[1] = w[23:16]; b[2] = w[15:8]; b[3] = w[7:0];
    return b;
  endfunction

  function automatic logic [31:0] tb_word(input mem_bytes_t b);
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic logic [31:0] rom(input logic [7:0] i);
    case (i)
      8'h04:   return 32'hA0A0_A0A0;   // 0x10
      8'h08:   return 32'hB0B0_B0B0;   // 0x20
      8'h10:   return 32'h1234_5678;   // 0x40
      default: return 32'h0000_0000;
    endcase
  endfunction

  logic [31:0]  wr_a [0:255];
  logic [31:0]  wr_b [0:255];
  logic [255:0] wv_a = '0;
  logic [255:0] wv_b = '0;
  logic [7:0]   ia, ib;
  int           strobes_a = 0;
  int           strobes_b = 0;

  assign ia = bus_a.mem_addr[9:2];
  assign ib = bus_b.mem_addr[9:2];
  assign bus_a.mem_data_out = tb_bytes(wv_a[ia] ? wr_a[ia] : rom(ia));
  assign bus_b.mem_data_out = tb_bytes(wv_b[ib] ? wr_b[ib] : rom(ib));

  always @(posedge clk) begin
    if (rst_b && bus_a.mem_write_en) begin
      wr_a[ia]  <= tb_word(bus_a.mem_data_in);
      wv_a[ia]  <= 1'b1;
      strobes_a <= strobes_a + 1;
    end
    if (rst_b && bus_b.mem_write_en) begin
      wr_b[ib]  <= tb_word(bus_b.mem_data_in);
      wv_b[ib]  <= 1'b1;
      strobes_b <= strobes_b + 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [1:0] g; int gap; } gexp_t;
  typedef struct { logic [1:0] rv; logic [31:0] rd; } rexp_t;

  gexp_t       qg_a[$], qg_b[$];
  rexp_t       qr_a[$], qr_b[$];
  int          gcnt[2]  = '{0, 0};
  int          lastg[2] = '{0, 0};
  int          cyc = 0;
  logic [31:0] mrd_a = '0;
  logic [31:0] mrd_b = '0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic fail(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    bad++;
    $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic exp_access(input int d, input logic [1:0] g, input int gap,
                            input bit wr, input logic [31:0] rd);
    gexp_t ge;
    rexp_t re;
    ge.g = g; ge.gap = gap; re.rv = g;
    if (d == 0) begin
      if (!wr) mrd_a = rd;
      re.rd = mrd_a;
      qg_a.push_back(ge); qr_a.push_back(re);
    end else begin
      if (!wr) mrd_b = rd;
      re.rd = mrd_b;
      qg_b.push_back(ge); qr_b.push_back(re);
    end
  endtask

  task automatic mon(input int d, input logic [1:0] g, input logic [1:0] rv,
                     input logic [31:0] rd);
    gexp_t ge;
    rexp_t re;
    bit    have;
    int    lat;
    lat = (d == 0) ? LAT_A : LAT_B;
    if ((g != 0) || (rv != 0))
      chk($sformatf("onehot[%0d]", d), $countones({g, rv}), 1);
    if (g != 0) begin
      gcnt[d]++;
      have = 1'b0;
      if (d == 0 && qg_a.size() > 0) begin ge = qg_a.pop_front(); have = 1'b1; end
      if (d == 1 && qg_b.size() > 0) begin ge = qg_b.pop_front(); have = 1'b1; end
      if (!have) fail($sformatf("unexpected_gnt[%0d]", d), g, 0);
      else begin
        chk($sformatf("gnt[%0d]", d), g, ge.g);
        if (ge.gap >= 0) chk($sformatf("gnt_gap[%0d]", d), cyc - lastg[d], ge.gap);
      end
      lastg[d] = cyc;
    end
    if (rv != 0) begin
      have = 1'b0;
      if (d == 0 && qr_a.size() > 0) begin re = qr_a.pop_front(); have = 1'b1; end
      if (d == 1 && qr_b.size() > 0) begin re = qr_b.pop_front(); have = 1'b1; end
      if (!have) fail($sformatf("unexpected_rvalid[%0d]", d), rv, 0);
      else begin
        chk($sformatf("rvalid[%0d]", d), rv, re.rv);
        chk($sformatf("rdata[%0d]", d), rd, re.rd);
        chk($sformatf("rsp_latency[%0d]", d), cyc - lastg[d], lat + 1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_b) begin
      mon(0, bus_a.gnt, bus_a.rvalid, bus_a.rdata);
      mon(1, bus_b.gnt, bus_b.rvalid, bus_b.rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int d, input int n);
    int k;
    k = 0;
    while (gcnt[d] < n && k < 200) begin tick(); k++; end
    if (gcnt[d] < n) fail($sformatf("gnt_timeout[%0d]", d), gcnt[d], n);
  endtask

  task automatic wait_idle(input int d);
    int k;
    k = 0;
    while (((d == 0) ? qr_a.size() : qr_b.size()) > 0 && k < 200) begin tick(); k++; end
    if (((d == 0) ? qr_a.size() : qr_b.size()) > 0)
      fail($sformatf("rsp_timeout[%0d]", d), (d == 0) ? qr_a.size() : qr_b.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int s0;
    rst_b = 1'b0; halted_a = 1'b0; halted_b = 1'b0;
    bus_a.req = '0; bus_a.we = '0; bus_a.addr_0 = '0; bus_a.addr_1 = '0;
    bus_a.wdata_0 = '0; bus_a.wdata_1 = '0;
    bus_b.req = '0; bus_b.we = '0; bus_b.addr_0 = '0; bus_b.addr_1 = '0;
    bus_b.wdata_0 = '0; bus_b.wdata_1 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt",      bus_a.gnt, 0);
    chk("rst_rvalid",   bus_a.rvalid, 0);
    chk("rst_busy",     bus_a.busy, 0);
    chk("rst_wen",      bus_a.mem_write_en, 0);
    chk("rst_rdata",    bus_a.rdata, 0);
    chk("rst_mem_addr", bus_a.mem_addr, 0);
    chk("rst_mem_din",  bus_a.mem_data_in, 0);
    chk("rst_busy_b",   bus_b.busy, 0);
    tick();
    rst_b = 1'b1;
    tick();

    // Single write on the latency-1 instance
    bus_b.req = 2'b01; bus_b.we = 2'b01;
    bus_b.addr_0 = 32'h100; bus_b.wdata_0 = 32'hDEAD_BEEF;
    exp_access(1, 2'b01, -1, 1'b1, 32'h0);
    wait_gnt(1, 1);
    bus_b.req = '0; bus_b.we = '0;
    @(negedge clk);
    chk("wr_wen_t1",    bus_b.mem_write_en, 1);
    chk("wr_busy_t1",   bus_b.busy, 1);
    chk("wr_addr",      bus_b.mem_addr, 32'h100);
    chk("wr_byte0",     bus_b.mem_data_in[0], 8'hDE);
    chk("wr_byte1",     bus_b.mem_data_in[1], 8'hAD);
    chk("wr_byte2",     bus_b.mem_data_in[2], 8'hBE);
    chk("wr_byte3",     bus_b.mem_data_in[3], 8'hEF);
    @(negedge clk);
    chk("wr_wen_t2",    bus_b.mem_write_en, 0);
    wait_idle(1);
    chk("wr_strobes",   strobes_b, 1);
    chk("wr_addr_hold", bus_b.mem_addr, 32'h100);

    // Read the word back through the loader port
    bus_b.req = 2'b10; bus_b.addr_1 = 32'h100;
    exp_access(1, 2'b10, -1, 1'b0, 32'hDEAD_BEEF);
    wait_gnt(1, 2);
    bus_b.req = '0;
    wait_idle(1);

    // Single read, latency 3
    s0 = strobes_a;
    bus_a.req = 2'b10; bus_a.we = 2'b00; bus_a.addr_1 = 32'h40;
    exp_access(0, 2'b10, -1, 1'b0, 32'h1234_5678);
    wait_gnt(0, 1);
    bus_a.req = '0;
    wait_idle(0);
    chk("rd_no_strobe", strobes_a - s0, 0);

    // Contention, four accesses with both requests held
    bus_a.req = 2'b11; bus_a.we = 2'b00;
    bus_a.addr_0 = 32'h10; bus_a.addr_1 = 32'h20;
    exp_access(0, 2'b01, -1, 1'b0, 32'hA0A0_A0A0);
    exp_access(0, 2'b10, LAT_A + 2, 1'b0, 32'hB0B0_B0B0);
    exp_access(0, 2'b01, LAT_A + 2, 1'b0, 32'hA0A0_A0A0);
    exp_access(0, 2'b10, LAT_A + 2, 1'b0, 32'hB0B0_B0B0);
    wait_gnt(0, 5);
    bus_a.req = '0;
    wait_idle(0);

    // Halt masking: only the loader is served until halted drops
    s0 = strobes_a;
    halted_a = 1'b1;
    bus_a.req = 2'b11; bus_a.we = 2'b10;
    bus_a.addr_0 = 32'h30; bus_a.addr_1 = 32'h30; bus_a.wdata_1 = 32'hCAFE_0001;
    exp_access(0, 2'b10, -1, 1'b1, 32'h0);
    exp_access(0, 2'b10, LAT_A + 2, 1'b1, 32'h0);
    exp_access(0, 2'b01, LAT_A + 2, 1'b0, 32'hCAFE_0001);
    wait_gnt(0, 7);
    halted_a = 1'b0;
    wait_gnt(0, 8);
    bus_a.req = '0; bus_a.we = '0;
    wait_idle(0);
    chk("halt_strobes", strobes_a - s0, 2);

    // Halt rising mid-access; a short-lived loader request is never granted
    bus_a.req = 2'b01; bus_a.addr_0 = 32'h40; bus_a.addr_1 = 32'h20;
    exp_access(0, 2'b01, -1, 1'b0, 32'h1234_5678);
    wait_gnt(0, 9);
    halted_a = 1'b1;
    bus_a.req = 2'b10;
    tick();
    bus_a.req = '0;
    wait_idle(0);
    halted_a = 1'b0;

    // Reset during the first ACCESS cycle of a write
    s0 = strobes_a;
    bus_a.req = 2'b01; bus_a.we = 2'b01;
    bus_a.addr_0 = 32'h50; bus_a.wdata_0 = 32'h1111_1111;
    qg_a.push_back('{g: 2'b01, gap: -1});
    wait_gnt(0, 10);
    bus_a.req = '0; bus_a.we = '0;
    chk("abort_wen_before", bus_a.mem_write_en, 1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("abort_wen_after",  bus_a.mem_write_en, 0);
    chk("abort_busy",       bus_a.busy, 0);
    chk("abort_mem_addr",   bus_a.mem_addr, 0);
    mrd_a = '0;
    mrd_b = '0;
    tick();
    rst_b = 1'b1;
    chk("abort_strobes",    strobes_a - s0, 0);

    // After reset, requester 0 wins the first contention
    bus_a.req = 2'b11; bus_a.we = 2'b00;
    bus_a.addr_0 = 32'h10; bus_a.addr_1 = 32'h20;
    exp_access(0, 2'b01, -1, 1'b0, 32'hA0A0_A0A0);
    exp_access(0, 2'b10, LAT_A + 2, 1'b0, 32'hB0B0_B0B0);
    wait_gnt(0, 12);
    bus_a.req = '0;
    wait_idle(0);
    repeat (3) tick();

    chk("leftover_gnt", qg_a.size() + qg_b.size(), 0);
    chk("leftover_rsp", qr_a.size() + qr_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
